axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Parameter C_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_OFFSET_WIDTH, default 32, address width.
REQ-003 Parameter MEM_WORDS, default 4096, RAM depth in 32-bit words; power of two.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 S_AXI_AWADDR  in  C_OFFSET_WIDTH  write burst start byte address.
REQ-007 S_AXI_AWLEN  in  8  write beats minus 1.
REQ-008 S_AXI_AWVALID in / S_AXI_AWREADY out  1 each  AW handshake.
REQ-009 S_AXI_WDATA  in  32  write beat data.
REQ-010 S_AXI_WSTRB  in  4  byte enables; bit n covers WDATA[8n+7:8n].
REQ-011 S_AXI_WLAST  in  1  last write beat marker.
REQ-012 S_AXI_WVALID in / S_AXI_WREADY out  1 each  W handshake.
REQ-013 S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 S_AXI_BVALID out / S_AXI_BREADY in  1 each  B handshake.
REQ-015 S_AXI_ARADDR  in  C_OFFSET_WIDTH  read burst start byte address.
REQ-016 S_AXI_ARLEN  in  8  read beats minus 1.
REQ-017 S_AXI_ARVALID in / S_AXI_ARREADY out  1 each  AR handshake.
REQ-018 S_AXI_RDATA  out  32  read beat data.
REQ-019 S_AXI_RRESP  out  2  per-beat response, same encoding as BRESP.
REQ-020 S_AXI_RLAST  out  1  last read beat marker.
REQ-021 S_AXI_RVALID out / S_AXI_RREADY in  1 each  R handshake.
REQ-022 LOAD_WREN  in  1  backdoor full-word write enable for program loading.
REQ-023 LOAD_ADDR  in  C_OFFSET_WIDTH  backdoor byte address.
REQ-024 LOAD_DATA  in  32  backdoor write data.

Function
REQ-025 Bursts are always treated as INCR, full-width 4-byte beats; word index = addr[2 +: log2(MEM_WORDS)]; address bits [1:0] ignored.
REQ-026 The write FSM has states W_IDLE, W_DATA and W_RESP; AWREADY=1 only in W_IDLE; an AW handshake latches address and AWLEN+1 and moves to W_DATA.
REQ-027 In W_DATA, WREADY=1 except while LOAD_WREN=1; each accepted beat writes the bytes enabled by WSTRB, then the address increments by 4.
REQ-028 The burst ends on the (AWLEN+1)th accepted beat regardless of WLAST; the FSM moves to W_RESP with BVALID=1.
REQ-029 BRESP=SLVERR if any beat's address is at or above MEM_WORDS*4, or if WLAST disagrees with beat position; otherwise OKAY; out-of-range beats do not modify memory.
REQ-030 In W_RESP, BVALID and BRESP are held until BREADY=1; on that handshake the FSM returns to W_IDLE.
REQ-031 The read FSM has states R_IDLE and R_DATA; ARREADY=1 only in R_IDLE; an AR handshake latches address and count.
REQ-032 The first RVALID is asserted exactly 1 cycle after the AR handshake; each subsequent beat follows 1 cycle after the previous R handshake, or in the same cycle when pipelined back-to-back.
REQ-033 RDATA, RRESP and RLAST are stable while RVALID=1 and RREADY=0; RLAST=1 on beat ARLEN+1 only; after that handshake the FSM returns to R_IDLE.
REQ-034 An out-of-range read beat returns RDATA=0 and RRESP=SLVERR; in-range beats return OKAY.
REQ-035 Read and write FSMs run independently; a same-cycle write and read to one word returns the pre-write data.
REQ-036 LOAD_WREN has priority over an AXI write beat in the same cycle; out-of-range LOAD_ADDR is ignored.
REQ-037 The burst address does not wrap at the memory top; beats past the end take the out-of-range behaviour.

Reset
REQ-038 While RST=1: both FSMs are idle; AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; BRESP, RRESP and RDATA are 0; memory contents are preserved.
REQ-039 After RST deasserts, AWREADY and ARREADY are 1 on the first clock edge; reset asserted mid-burst abandons the burst with no response.

Verification
REQ-040 Load 0x00000013 via LOAD to address 0x0, then AR at 0x0 with ARLEN=0 -> one beat, RDATA=0x00000013, RRESP=0, RLAST=1, 1 cycle after the AR handshake.
REQ-041 AW at 0x100 with AWLEN=3, data 1..4, WSTRB=0xF, then AR at 0x100 with ARLEN=3 -> BRESP=0; reads return 1, 2, 3, 4; RLAST only on the 4th beat.
REQ-042 Write 0xAABBCCDD to 0x40 with WSTRB=0x5 over prior contents 0 -> a read of 0x40 returns 0x00BB00DD.
REQ-043 Burst at MEM_WORDS*4-4 with LEN=1 -> the write gives BRESP=SLVERR with only the first word changed; the read gives beat 1 OKAY and beat 2 RDATA=0 with SLVERR.
REQ-044 Hold RREADY=0 for 5 cycles mid-burst -> RDATA and RLAST unchanged; BREADY=0 -> BVALID held; RST pulsed mid-burst -> all valids 0 and ARREADY=AWREADY=1 after release.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI4 burst RAM slave: INCR-only full-word beats, independent read/write FSMs,
// plus a backdoor word-write port for program loading.
module axi_ram_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 32,
  parameter int MEM_WORDS        = 4096
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          LOAD_WREN,
  input  logic [C_OFFSET_WIDTH-1:0]     LOAD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   LOAD_DATA
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Any set bit above the word-index field means the byte address is past the RAM top.
  function automatic logic in_range(input logic [C_OFFSET_WIDTH-1:0] a);
    return (a >> (AW + 2)) == '0;
  endfunction

  logic [DW-1:0] mem_q [MEM_WORDS];

  wstate_e                   wstate_q, wstate_d;
  logic [C_OFFSET_WIDTH-1:0] waddr_q, waddr_d;
  logic [8:0]                wcnt_q, wcnt_d;
  logic                      werr_q, werr_d;

  rstate_e                   rstate_q, rstate_d;
  logic [C_OFFSET_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]                rrem_q, rrem_d;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;

  logic                      w_beat;
  logic                      w_last;
  logic [AW-1:0]             widx;
  logic [C_OFFSET_WIDTH-1:0] rd_sel;
  logic                      rd_ok;
  logic [DW-1:0]             rd_word;

  assign S_AXI_AWREADY = (wstate_q == W_IDLE) && !RST;
  assign S_AXI_WREADY  = (wstate_q == W_DATA) && !LOAD_WREN;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = (wstate_q == W_RESP && werr_q) ? SLVERR : OKAY;
  assign S_AXI_ARREADY = (rstate_q == R_IDLE) && !RST;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

  assign w_beat = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last = (wcnt_q == 9'd1);
  assign widx   = waddr_q[AW+1:2];

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    case (wstate_q)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        waddr_d  = S_AXI_AWADDR;
        wcnt_d   = {1'b0, S_AXI_AWLEN} + 9'd1;
        werr_d   = 1'b0;
        wstate_d = W_DATA;
      end
      W_DATA: if (w_beat) begin
        waddr_d = waddr_q + C_OFFSET_WIDTH'(4);
        wcnt_d  = wcnt_q - 9'd1;
        if (!in_range(waddr_q) || (S_AXI_WLAST != w_last)) werr_d = 1'b1;
        if (w_last) wstate_d = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // The first beat is fetched from ARADDR directly so it is valid one cycle after AR.
  assign rd_sel  = (rstate_q == R_IDLE) ? S_AXI_ARADDR : raddr_q;
  assign rd_ok   = in_range(rd_sel);
  assign rd_word = rd_ok ? mem_q[rd_sel[AW+1:2]] : '0;

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rrem_d   = rrem_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    case (rstate_q)
      R_IDLE: if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        rdata_d  = rd_word;
        rresp_d  = rd_ok ? OKAY : SLVERR;
        rlast_d  = (S_AXI_ARLEN == 8'd0);
        rrem_d   = S_AXI_ARLEN;
        raddr_d  = S_AXI_ARADDR + C_OFFSET_WIDTH'(4);
        rstate_d = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) begin
        if (rlast_q) begin
          rlast_d  = 1'b0;
          rstate_d = R_IDLE;
        end else begin
          rdata_d = rd_word;
          rresp_d = rd_ok ? OKAY : SLVERR;
          rlast_d = (rrem_q == 8'd1);
          rrem_d  = rrem_q - 8'd1;
          raddr_d = raddr_q + C_OFFSET_WIDTH'(4);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rrem_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rrem_q   <= rrem_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  // Storage is deliberately not reset so a loaded program survives RST.
  always_ff @(posedge CLK) begin
    if (LOAD_WREN) begin
      if (in_range(LOAD_ADDR)) mem_q[LOAD_ADDR[AW+1:2]] <= LOAD_DATA;
    end else if (w_beat && in_range(waddr_q)) begin
      for (int unsigned b = 0; b < DW / 8; b++)
        if (S_AXI_WSTRB[b]) mem_q[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: backdoor load, bursts, strobes, range errors,
// stalls, same-cycle read/write and mid-burst reset.
module tb_axi_ram_slave;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, LOAD_ADDR = '0, LOAD_DATA = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0, LOAD_WREN = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wd [4];
  logic [31:0] ed [4];
  logic [1:0]  er [4];

  always #5 CLK = ~CLK;

  axi_ram_slave #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(32), .MEM_WORDS(4096)) dut (
    .CLK(CLK), .RST(RST),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID),
    .S_AXI_RREADY(RREADY), .LOAD_WREN(LOAD_WREN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK); LOAD_WREN = 1; LOAD_ADDR = a; LOAD_DATA = d;
    @(negedge CLK); LOAD_WREN = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] strb,
                          input bit bad_last, input int bhold, input logic [1:0] eresp);
    @(negedge CLK); AWADDR = a; AWLEN = len; AWVALID = 1;
    for (int k = 0; k < 20 && AWREADY !== 1'b1; k++) @(negedge CLK);
    chk("awready", 32'(AWREADY), 32'd1);
    @(posedge CLK); @(negedge CLK); AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = strb; WLAST = (i == int'(len)) ^ bad_last; WVALID = 1;
      for (int k = 0; k < 20 && WREADY !== 1'b1; k++) @(negedge CLK);
      chk("wready", 32'(WREADY), 32'd1);
      @(posedge CLK); @(negedge CLK);
    end
    WVALID = 0; WLAST = 0;
    for (int k = 0; k < 20 && BVALID !== 1'b1; k++) @(negedge CLK);
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'(eresp));
    repeat (bhold) begin
      @(negedge CLK);
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("bresp_hold", 32'(BRESP), 32'(eresp));
    end
    BREADY = 1; @(posedge CLK); @(negedge CLK); BREADY = 0;
    chk("b_done", 32'(BVALID), 32'd0);
    chk("awready_again", 32'(AWREADY), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int stall_beat);
    @(negedge CLK); ARADDR = a; ARLEN = len; ARVALID = 1;
    for (int k = 0; k < 20 && ARREADY !== 1'b1; k++) @(negedge CLK);
    chk("arready", 32'(ARREADY), 32'd1);
    chk("rvalid_pre", 32'(RVALID), 32'd0);
    @(posedge CLK); @(negedge CLK); ARVALID = 0; RREADY = 1;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        RREADY = 0;
        repeat (5) begin
          @(negedge CLK);
          chk("stall_rvalid", 32'(RVALID), 32'd1);
          chk("stall_rdata", RDATA, ed[i]);
          chk("stall_rlast", 32'(RLAST), 32'(i == int'(len)));
        end
        RREADY = 1;
      end
      chk("rvalid", 32'(RVALID), 32'd1);
      chk("rdata", RDATA, ed[i]);
      chk("rresp", 32'(RRESP), 32'(er[i]));
      chk("rlast", 32'(RLAST), 32'(i == int'(len)));
      @(posedge CLK); @(negedge CLK);
    end
    RREADY = 0;
    chk("r_done", 32'(RVALID), 32'd0);
    chk("arready_again", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while RST is held
    @(negedge CLK); @(negedge CLK);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_wready",  32'(WREADY),  32'd0);
    chk("rst_bvalid",  32'(BVALID),  32'd0);
    chk("rst_rvalid",  32'(RVALID),  32'd0);
    chk("rst_rlast",   32'(RLAST),   32'd0);
    chk("rst_bresp",   32'(BRESP),   32'd0);
    chk("rst_rresp",   32'(RRESP),   32'd0);
    chk("rst_rdata",   RDATA,        32'd0);
    RST = 0;
    @(negedge CLK);
    chk("post_rst_awready", 32'(AWREADY), 32'd1);
    chk("post_rst_arready", 32'(ARREADY), 32'd1);

    // Backdoor load then single-beat read
    load(32'h0, 32'h0000_0013);
    ed[0] = 32'h13; er[0] = 2'b00;
    do_read(32'h0, 8'd0, -1);

    // 4-beat burst write/read, with BREADY held low for 3 cycles
    wd = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(32'h100, 8'd3, 4'hF, 1'b0, 3, 2'b00);
    ed = '{32'd1, 32'd2, 32'd3, 32'd4}; er = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_read(32'h100, 8'd3, -1);

    // Same burst read with RREADY stalled 5 cycles on beat 3
    do_read(32'h100, 8'd3, 2);

    // Partial byte strobes
    load(32'h40, 32'h0);
    wd[0] = 32'hAABB_CCDD;
    do_write(32'h40, 8'd0, 4'h5, 1'b0, 0, 2'b00);
    ed[0] = 32'h00BB_00DD; er[0] = 2'b00;
    do_read(32'h40, 8'd0, -1);

    // Burst crossing the memory top, no wrap to word 0; out-of-range load ignored
    load(32'h4000, 32'hDEAD_BEEF);
    wd = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
    do_write(32'h3FFC, 8'd1, 4'hF, 1'b0, 0, 2'b10);
    ed = '{32'h1111_1111, 32'h0, 32'h0, 32'h0}; er = '{2'b00, 2'b10, 2'b00, 2'b00};
    do_read(32'h3FFC, 8'd1, -1);
    ed[0] = 32'h13; er[0] = 2'b00;
    do_read(32'h0, 8'd0, -1);

    // WLAST on the wrong beat: SLVERR but in-range data still written
    wd = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h0};
    do_write(32'h200, 8'd1, 4'hF, 1'b1, 0, 2'b10);
    ed = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h0}; er = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_read(32'h200, 8'd1, -1);

    // LOAD stalls WREADY; same-cycle write+read of one word returns old data
    load(32'h300, 32'h0000_000A);
    @(negedge CLK); AWADDR = 32'h300; AWLEN = 8'd0; AWVALID = 1;
    @(posedge CLK); @(negedge CLK); AWVALID = 0;
    LOAD_WREN = 1; LOAD_ADDR = 32'h304; LOAD_DATA = 32'h55;
    #1 chk("load_blocks_wready", 32'(WREADY), 32'd0);
    @(negedge CLK); LOAD_WREN = 0;
    WDATA = 32'hB; WSTRB = 4'hF; WLAST = 1; WVALID = 1;
    ARADDR = 32'h300; ARLEN = 8'd0; ARVALID = 1;
    #1 chk("coincident_ready", 32'({WREADY, ARREADY}), 32'd3);
    @(posedge CLK); @(negedge CLK);
    WVALID = 0; WLAST = 0; ARVALID = 0;
    chk("rw_same_cycle_old", RDATA, 32'hA);
    chk("rw_same_cycle_bresp", 32'({BVALID, BRESP}), 32'b100);
    RREADY = 1; BREADY = 1;
    @(posedge CLK); @(negedge CLK); RREADY = 0; BREADY = 0;
    ed = '{32'hB, 32'h55, 32'h0, 32'h0}; er = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_read(32'h300, 8'd1, -1);

    // Reset pulsed mid-burst on both channels
    @(negedge CLK); AWADDR = 32'h500; AWLEN = 8'd3; AWVALID = 1;
    ARADDR = 32'h100; ARLEN = 8'd3; ARVALID = 1;
    @(posedge CLK); @(negedge CLK); AWVALID = 0; ARVALID = 0;
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1;
    @(posedge CLK); @(negedge CLK); WVALID = 0;
    chk("midburst_rvalid", 32'(RVALID), 32'd1);
    RST = 1;
    #1;
    chk("rst_mid_rvalid",  32'(RVALID),  32'd0);
    chk("rst_mid_bvalid",  32'(BVALID),  32'd0);
    chk("rst_mid_wready",  32'(WREADY),  32'd0);
    chk("rst_mid_awready", 32'(AWREADY), 32'd0);
    @(negedge CLK); RST = 0;
    @(negedge CLK);
    chk("rel_awready", 32'(AWREADY), 32'd1);
    chk("rel_arready", 32'(ARREADY), 32'd1);
    chk("rel_rvalid",  32'(RVALID),  32'd0);
    chk("rel_bvalid",  32'(BVALID),  32'd0);
    chk("rel_wready",  32'(WREADY),  32'd0);
    ed = '{32'd1, 32'd2, 32'd3, 32'd4}; er = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_read(32'h100, 8'd3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
